red_pitaya_daisy_rx_frame: RTL and testbench
============================================

// Module: red_pitaya_daisy_rx_frame
// PURPOSE
//  Frame parser directly downstream of the daisy-chain RX deserializer. It consumes
//  the trained 16-bit word stream (dat/dv) in the parallel RX clock domain and
//  delineates frames as SOF header, payload, checksum. Payload is buffered in a
//  FIFO with valid/ready, last and error flags for the next stage (CDC/regset).
// PARAMETERS
//  FIFO_AW    4        log2 of payload FIFO depth (16 words)
//  SOF_TAG    8'hA5    header tag, matched against word[15:8]
//  IDLE_WORD  16'h00FF link idle/training word, silently discarded
//  TIMEOUT    64       max cycles without dv inside a frame before abort (>=2)
// PORTS
//  clk_i          in   1   parallel RX clock (same clock as upstream par_clk_o)
//  rst_i          in   1   asynchronous reset, active high
//  cfg_en_i       in   1   enable; low = sync flush (FSM IDLE, FIFO empty, hold cleared)
//  rx_dat_i       in   16  received word
//  rx_dv_i        in   1   rx_dat_i valid (one word per cycle max)
//  m_dat_o        out  16  payload word
//  m_last_o       out  1   last payload word of frame
//  m_err_o        out  1   frame errored; meaningful only with m_last_o
//  m_valid_o      out  1   output word valid
//  m_ready_i      in   1   downstream accepts when m_valid_o && m_ready_i
//  frame_ok_o     out  1   1-cycle pulse, frame closed with good checksum, no drop
//  frame_err_o    out  1   1-cycle pulse, header/checksum/timeout/overflow error
//  ovf_o          out  1   sticky: FIFO full on push; cleared only by cfg_en_i low
//  busy_o         out  1   FSM not in IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE, FIFO empty, hold invalid, sum=0, all outputs 0.
//  FSM IDLE: on dv, word[15:8]==SOF_TAG && len=word[7:0]!=0 -> PAYLOAD, cnt=len,
//   sum=0, drop=0. len==0 -> frame_err pulse, stay IDLE. IDLE_WORD or other -> discard.
//  PAYLOAD: on dv, sum<=sum+word (mod 2^16); if hold valid push {hold,last=0};
//   hold<=word; cnt--; when cnt==1 at dv -> CSUM.
//  CSUM: on dv push {hold,last=1,err=(word!=sum)||drop}; pulse frame_ok or frame_err
//   the cycle after; -> IDLE. Checksum word is never output.
//  Timeout: gap counter clears on each dv, counts in PAYLOAD/CSUM; reaching TIMEOUT
//   -> push {hold,last=1,err=1} if hold valid, frame_err pulse, -> IDLE.
//  Latency: payload word k is written when word k+1 (or checksum) arrives; FIFO
//   write at that edge, m_valid_o earliest next cycle (registered read, show-ahead).
//  FIFO full at push: word dropped, ovf_o<=1, drop<=1 -> frame closes with err=1.
//   If the dropped word is the last, no last beat emitted; frame_err still pulses.
//  Simultaneous push and pop on full FIFO: pop frees space first -> push succeeds.
//  m_dat/last/err stable while m_valid_o && !m_ready_i.
//  SOF seen in PAYLOAD/CSUM is treated as data (no resync); timeout recovers.
//  cfg_en_i low mid-frame: hold/FIFO discarded, no pulses; ovf_o cleared.
//  Upstream guarantees dv only when trained; no backpressure to rx side exists.
// CONFIGURATION
//  DAISY_RX_FRAME_STATS_EN defined: adds outputs stat_frm_o[31:0] (frames closed ok)
//   and stat_err_o[31:0] (frame_err pulses), saturating at 32'hFFFFFFFF, reset 0,
//   cleared by cfg_en_i low.
//  Undefined: ports still present, tied to 32'h0; no counter logic.
// TESTING
//  A503,0001,0002,0003,0006 -> out 0001,0002,0003(last,err=0); frame_ok 1 pulse.
//  A502,1234,0010,FFFF (bad sum, exp 1244) -> 1234,0010(last,err=1); frame_err pulse.
//  00FF x5, A500, 00FF -> no output, one frame_err pulse, busy_o stays 0 after.
//  A514 + 20 words, m_ready_i=0 -> 16 words held, ovf_o=1, frame_err; ready=1 drains 16.
//  A504,0001 then 64 idle cycles -> 0001(last,err=1), frame_err, busy_o=0.
//  rst_i asserted mid-payload -> outputs 0 async; next A501,0005,0005 parses ok.

Source files
------------

// File: rtl/red_pitaya_daisy_rx_frame.sv
// Daisy-chain RX frame parser: SOF/len header, payload, checksum -> payload FIFO.
// Define DAISY_RX_FRAME_STATS_EN to enable the frame/error statistics counters.
module red_pitaya_daisy_rx_frame #(
    parameter int unsigned FIFO_AW   = 4,
    parameter logic [7:0]  SOF_TAG   = 8'hA5,
    parameter logic [15:0] IDLE_WORD = 16'h00FF,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cfg_en_i,
    input  logic [15:0] rx_dat_i,
    input  logic        rx_dv_i,
    output logic [15:0] m_dat_o,
    output logic        m_last_o,
    output logic        m_err_o,
    output logic        m_valid_o,
    input  logic        m_ready_i,
    output logic        frame_ok_o,
    output logic        frame_err_o,
    output logic        ovf_o,
    output logic        busy_o,
    output logic [31:0] stat_frm_o,
    output logic [31:0] stat_err_o
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned GW    = $clog2(TIMEOUT + 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_ONE = GW'(1);
    localparam logic [FIFO_AW:0] PTR_ONE = (FIFO_AW + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAYLOAD,
        S_CSUM
    } state_t;

    state_t           state;
    logic [7:0]       cnt;
    logic [15:0]      sum;
    logic [15:0]      hold;
    logic             hold_vld;
    logic             drop;
    logic [GW-1:0]    gap;

    logic [17:0]      mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic [17:0]      rd_ent;

    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push_req;
    logic push_last;
    logic push_err;
    logic push_ok;
    logic push_drop;
    logic tmo;
    logic csum_bad;
    logic sof_hit;

    assign csum_bad = rx_dat_i != sum;
    assign sof_hit  = rx_dv_i && (rx_dat_i != IDLE_WORD)
                      && (rx_dat_i[15:8] == SOF_TAG);

    always_comb begin
        tmo       = 1'b0;
        push_req  = 1'b0;
        push_last = 1'b0;
        push_err  = 1'b0;
        if (state != S_IDLE && !rx_dv_i && gap == GAP_MAX)
            tmo = 1'b1;
        unique case (1'b1)
            (state == S_PAYLOAD) && rx_dv_i: push_req = hold_vld;
            (state == S_CSUM) && rx_dv_i: begin
                push_req  = hold_vld;
                push_last = 1'b1;
                push_err  = csum_bad || drop;
            end
            tmo: begin
                push_req  = hold_vld;
                push_last = 1'b1;
                push_err  = 1'b1;
            end
            default: ;
        endcase
    end

    assign fifo_empty = wr_ptr == rd_ptr;
    assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW])
                        && (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign pop        = !fifo_empty && m_ready_i;
    assign push_ok    = push_req && (!fifo_full || pop);
    assign push_drop  = push_req && fifo_full && !pop;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            cnt         <= '0;
            sum         <= '0;
            hold        <= '0;
            hold_vld    <= 1'b0;
            drop        <= 1'b0;
            gap         <= '0;
            frame_ok_o  <= 1'b0;
            frame_err_o <= 1'b0;
            ovf_o       <= 1'b0;
        end else if (!cfg_en_i) begin
            state       <= S_IDLE;
            cnt         <= '0;
            sum         <= '0;
            hold        <= '0;
            hold_vld    <= 1'b0;
            drop        <= 1'b0;
            gap         <= '0;
            frame_ok_o  <= 1'b0;
            frame_err_o <= 1'b0;
            ovf_o       <= 1'b0;
        end else begin
            frame_ok_o  <= 1'b0;
            frame_err_o <= 1'b0;
            if (push_drop) begin
                ovf_o <= 1'b1;
                drop  <= 1'b1;
            end
            if (state == S_IDLE || rx_dv_i)
                gap <= '0;
            else
                gap <= gap + GAP_ONE;
            unique case (state)
                S_IDLE: begin
                    if (sof_hit) begin
                        if (rx_dat_i[7:0] != 8'd0) begin
                            state <= S_PAYLOAD;
                            cnt   <= rx_dat_i[7:0];
                            sum   <= '0;
                            drop  <= 1'b0;
                        end else begin
                            frame_err_o <= 1'b1;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (rx_dv_i) begin
                        sum      <= sum + rx_dat_i;
                        hold     <= rx_dat_i;
                        hold_vld <= 1'b1;
                        cnt      <= cnt - 8'd1;
                        if (cnt == 8'd1)
                            state <= S_CSUM;
                    end else if (tmo) begin
                        state       <= S_IDLE;
                        hold_vld    <= 1'b0;
                        frame_err_o <= 1'b1;
                    end
                end
                S_CSUM: begin
                    if (rx_dv_i) begin
                        state    <= S_IDLE;
                        hold_vld <= 1'b0;
                        if (csum_bad || drop || push_drop)
                            frame_err_o <= 1'b1;
                        else
                            frame_ok_o <= 1'b1;
                    end else if (tmo) begin
                        state       <= S_IDLE;
                        hold_vld    <= 1'b0;
                        frame_err_o <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (!cfg_en_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && cfg_en_i)
            mem[wr_ptr[FIFO_AW-1:0]] <= {push_err, push_last, hold};
    end

    assign rd_ent    = mem[rd_ptr[FIFO_AW-1:0]];
    assign m_valid_o = !fifo_empty;
    assign m_dat_o   = m_valid_o ? rd_ent[15:0] : 16'h0;
    assign m_last_o  = m_valid_o && rd_ent[16];
    assign m_err_o   = m_valid_o && rd_ent[17];
    assign busy_o    = state != S_IDLE;

`ifdef DAISY_RX_FRAME_STATS_EN
    logic [31:0] stat_frm;
    logic [31:0] stat_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_frm <= '0;
            stat_err <= '0;
        end else if (!cfg_en_i) begin
            stat_frm <= '0;
            stat_err <= '0;
        end else begin
            if (frame_ok_o && stat_frm != 32'hFFFF_FFFF)
                stat_frm <= stat_frm + 32'd1;
            if (frame_err_o && stat_err != 32'hFFFF_FFFF)
                stat_err <= stat_err + 32'd1;
        end
    end

    assign stat_frm_o = stat_frm;
    assign stat_err_o = stat_err;
`else
    assign stat_frm_o = 32'h0;
    assign stat_err_o = 32'h0;
`endif

endmodule

// File: tb/tb_red_pitaya_daisy_rx_frame.sv
// Self-checking bench for red_pitaya_daisy_rx_frame: directed spec cases
// plus randomized frames against a frame-level reference model.
module tb_red_pitaya_daisy_rx_frame;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cfg_en_i = 1'b1;
    logic [15:0] rx_dat_i = 16'h0;
    logic        rx_dv_i = 1'b0;
    logic [15:0] m_dat_o;
    logic        m_last_o;
    logic        m_err_o;
    logic        m_valid_o;
    logic        m_ready_i = 1'b0;
    logic        frame_ok_o;
    logic        frame_err_o;
    logic        ovf_o;
    logic        busy_o;
    logic [31:0] stat_frm_o;
    logic [31:0] stat_err_o;

    int checks = 0;
    int failures = 0;
    int ok_cnt = 0;
    int err_cnt = 0;
    logic [17:0] got_q[$];
    bit   rnd_ready = 1'b0;
    logic rdy_force = 1'b1;

    red_pitaya_daisy_rx_frame dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cfg_en_i   (cfg_en_i),
        .rx_dat_i   (rx_dat_i),
        .rx_dv_i    (rx_dv_i),
        .m_dat_o    (m_dat_o),
        .m_last_o   (m_last_o),
        .m_err_o    (m_err_o),
        .m_valid_o  (m_valid_o),
        .m_ready_i  (m_ready_i),
        .frame_ok_o (frame_ok_o),
        .frame_err_o(frame_err_o),
        .ovf_o      (ovf_o),
        .busy_o     (busy_o),
        .stat_frm_o (stat_frm_o),
        .stat_err_o (stat_err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        #1;
        m_ready_i = rnd_ready ? ($urandom_range(3) != 0) : rdy_force;
    end

    // err is only meaningful on the last beat, so it is masked with last
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (m_valid_o && m_ready_i)
                got_q.push_back({m_err_o & m_last_o, m_last_o, m_dat_o});
            if (frame_ok_o)
                ok_cnt++;
            if (frame_err_o)
                err_cnt++;
        end
    end

    task automatic drive(input logic dv, input logic [15:0] d);
        @(posedge clk_i);
        #1;
        rx_dv_i  = dv;
        rx_dat_i = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 16'h0);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if ({m_valid_o, m_last_o, m_err_o, frame_ok_o, frame_err_o, ovf_o, busy_o} !== 7'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=%b",
                     {m_valid_o, m_last_o, m_err_o, frame_ok_o, frame_err_o, ovf_o, busy_o}, 7'b0);
        end
        checks++;
        if (m_dat_o !== 16'h0) begin
            failures++;
            $display("FAIL reset_dat got=%h exp=0000", m_dat_o);
        end
        checks++;
        if ({stat_frm_o, stat_err_o} !== 64'h0) begin
            failures++;
            $display("FAIL reset_stats got=%h/%h exp=0/0", stat_frm_o, stat_err_o);
        end
        rst_i = 1'b0;
        idle(2);
    endtask

    task automatic test_basic();
        int base = got_q.size();
        int ok0 = ok_cnt;
        int er0 = err_cnt;
        logic [17:0] exp[3];
        exp[0] = {2'b00, 16'h0001};
        exp[1] = {2'b00, 16'h0002};
        exp[2] = {2'b01, 16'h0003};
        drive(1, 16'hA503); drive(1, 16'h0001); drive(1, 16'h0002);
        drive(1, 16'h0003); drive(1, 16'h0006);
        idle(10);
        checks++;
        if (got_q.size() - base != 3) begin
            failures++;
            $display("FAIL basic_count got=%0d exp=3", got_q.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_q[base+i] !== exp[i]) begin
                    failures++;
                    $display("FAIL basic_beat%0d got=%h exp=%h", i, got_q[base+i], exp[i]);
                end
            end
        end
        checks++;
        if (ok_cnt - ok0 != 1 || err_cnt - er0 != 0) begin
            failures++;
            $display("FAIL basic_pulses got ok=%0d err=%0d exp ok=1 err=0", ok_cnt - ok0, err_cnt - er0);
        end
    endtask

    task automatic test_bad_sum();
        int base = got_q.size();
        int ok0 = ok_cnt;
        int er0 = err_cnt;
        drive(1, 16'hA502); drive(1, 16'h1234); drive(1, 16'h0010); drive(1, 16'hFFFF);
        idle(10);
        checks++;
        if (got_q.size() - base != 2) begin
            failures++;
            $display("FAIL badsum_count got=%0d exp=2", got_q.size() - base);
        end else begin
            checks++;
            if (got_q[base] !== {2'b00, 16'h1234} || got_q[base+1] !== {2'b11, 16'h0010}) begin
                failures++;
                $display("FAIL badsum_beats got=%h,%h exp=%h,%h", got_q[base], got_q[base+1],
                         {2'b00, 16'h1234}, {2'b11, 16'h0010});
            end
        end
        checks++;
        if (ok_cnt - ok0 != 0 || err_cnt - er0 != 1) begin
            failures++;
            $display("FAIL badsum_pulses got ok=%0d err=%0d exp ok=0 err=1", ok_cnt - ok0, err_cnt - er0);
        end
    endtask

    task automatic test_idle_len0();
        int base = got_q.size();
        int er0 = err_cnt;
        repeat (5) drive(1, 16'h00FF);
        drive(1, 16'hA500);
        drive(1, 16'h00FF);
        idle(5);
        checks++;
        if (got_q.size() != base || err_cnt - er0 != 1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL len0 got beats=%0d err=%0d busy=%b exp beats=0 err=1 busy=0",
                     got_q.size() - base, err_cnt - er0, busy_o);
        end
    endtask

    task automatic test_back_to_back();
        int base = got_q.size();
        int ok0 = ok_cnt;
        logic [17:0] exp[3];
        exp[0] = {2'b01, 16'h0007};
        exp[1] = {2'b00, 16'h0001};
        exp[2] = {2'b01, 16'h0002};
        drive(1, 16'hA501); drive(1, 16'h0007); drive(1, 16'h0007);
        drive(1, 16'hA502); drive(1, 16'h0001); drive(1, 16'h0002); drive(1, 16'h0003);
        idle(10);
        checks++;
        if (got_q.size() - base != 3 || ok_cnt - ok0 != 2) begin
            failures++;
            $display("FAIL b2b_count got beats=%0d ok=%0d exp beats=3 ok=2", got_q.size() - base, ok_cnt - ok0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_q[base+i] !== exp[i]) begin
                    failures++;
                    $display("FAIL b2b_beat%0d got=%h exp=%h", i, got_q[base+i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int base = got_q.size();
        int ok0 = ok_cnt;
        int er0 = err_cnt;
        rdy_force = 1'b0;
        idle(2);
        drive(1, 16'hA514);
        for (int i = 1; i <= 20; i++) drive(1, 16'(i));
        drive(1, 16'h00D2);
        idle(3);
        checks++;
        if (m_valid_o !== 1'b1 || ovf_o !== 1'b1 || got_q.size() != base) begin
            failures++;
            $display("FAIL ovf_hold got valid=%b ovf=%b beats=%0d exp valid=1 ovf=1 beats=0",
                     m_valid_o, ovf_o, got_q.size() - base);
        end
        checks++;
        if (ok_cnt - ok0 != 0 || err_cnt - er0 != 1) begin
            failures++;
            $display("FAIL ovf_pulses got ok=%0d err=%0d exp ok=0 err=1", ok_cnt - ok0, err_cnt - er0);
        end
        rdy_force = 1'b1;
        idle(25);
        checks++;
        if (got_q.size() - base != 16 || m_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL ovf_drain got beats=%0d valid=%b exp beats=16 valid=0", got_q.size() - base, m_valid_o);
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (got_q[base+i] !== {2'b00, 16'(i + 1)}) begin
                    failures++;
                    $display("FAIL ovf_beat%0d got=%h exp=%h", i, got_q[base+i], {2'b00, 16'(i + 1)});
                end
            end
        end
        @(posedge clk_i);
        #1;
        cfg_en_i = 1'b0;
        idle(1);
        checks++;
        if (ovf_o !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear got=%b exp=0", ovf_o);
        end
        cfg_en_i = 1'b1;
        idle(1);
    endtask

    task automatic test_timeout();
        int base = got_q.size();
        int er0 = err_cnt;
        drive(1, 16'hA504);
        drive(1, 16'h0001);
        idle(60);
        checks++;
        if (busy_o !== 1'b1 || got_q.size() != base) begin
            failures++;
            $display("FAIL tmo_early got busy=%b beats=%0d exp busy=1 beats=0", busy_o, got_q.size() - base);
        end
        idle(10);
        checks++;
        if (busy_o !== 1'b0 || err_cnt - er0 != 1 || got_q.size() - base != 1) begin
            failures++;
            $display("FAIL tmo_end got busy=%b err=%0d beats=%0d exp busy=0 err=1 beats=1",
                     busy_o, err_cnt - er0, got_q.size() - base);
        end else begin
            checks++;
            if (got_q[base] !== {2'b11, 16'h0001}) begin
                failures++;
                $display("FAIL tmo_beat got=%h exp=%h", got_q[base], {2'b11, 16'h0001});
            end
        end
    endtask

    task automatic test_cfg_flush();
        int base;
        int ok0 = ok_cnt;
        int er0 = err_cnt;
        rdy_force = 1'b0;
        idle(2);
        drive(1, 16'hA503); drive(1, 16'h0001); drive(1, 16'h0002);
        idle(1);
        checks++;
        if (m_valid_o !== 1'b1 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL flush_pre got valid=%b busy=%b exp 1/1", m_valid_o, busy_o);
        end
        cfg_en_i = 1'b0;
        idle(1);
        cfg_en_i = 1'b1;
        checks++;
        if (m_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_post got valid=%b busy=%b exp 0/0", m_valid_o, busy_o);
        end
        rdy_force = 1'b1;
        idle(3);
        base = got_q.size();
        drive(1, 16'hA501); drive(1, 16'h0009); drive(1, 16'h0009);
        idle(8);
        checks++;
        if (got_q.size() - base != 1 || ok_cnt - ok0 != 1 || err_cnt - er0 != 0) begin
            failures++;
            $display("FAIL flush_next got beats=%0d ok=%0d err=%0d exp 1/1/0",
                     got_q.size() - base, ok_cnt - ok0, err_cnt - er0);
        end else begin
            checks++;
            if (got_q[base] !== {2'b01, 16'h0009}) begin
                failures++;
                $display("FAIL flush_beat got=%h exp=%h", got_q[base], {2'b01, 16'h0009});
            end
        end
    endtask

    task automatic test_rst_mid();
        int base;
        int ok0;
        rdy_force = 1'b0;
        idle(2);
        drive(1, 16'hA502); drive(1, 16'h0011); drive(1, 16'h0022);
        idle(1);
        checks++;
        if (m_valid_o !== 1'b1 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre got valid=%b busy=%b exp 1/1", m_valid_o, busy_o);
        end
        #2;
        rst_i = 1'b1;
        #1;
        checks++;
        if ({m_valid_o, m_last_o, m_dat_o, busy_o, frame_ok_o, frame_err_o} !== 21'h0) begin
            failures++;
            $display("FAIL rst_async got valid=%b dat=%h busy=%b exp 0/0000/0", m_valid_o, m_dat_o, busy_o);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        rdy_force = 1'b1;
        idle(2);
        base = got_q.size();
        ok0 = ok_cnt;
        drive(1, 16'hA501); drive(1, 16'h0005); drive(1, 16'h0005);
        idle(8);
        checks++;
        if (got_q.size() - base != 1 || ok_cnt - ok0 != 1) begin
            failures++;
            $display("FAIL rst_next got beats=%0d ok=%0d exp 1/1", got_q.size() - base, ok_cnt - ok0);
        end else begin
            checks++;
            if (got_q[base] !== {2'b01, 16'h0005}) begin
                failures++;
                $display("FAIL rst_beat got=%h exp=%h", got_q[base], {2'b01, 16'h0005});
            end
        end
    endtask

    task automatic send(input logic [15:0] w);
        drive(1, w);
        repeat ($urandom_range(3)) drive(1'b0, 16'($urandom));
    endtask

    task automatic test_random();
        int base = got_q.size();
        int ok0 = ok_cnt;
        int er0 = err_cnt;
        int eok = 0;
        int eer = 0;
        int kind;
        int len;
        bit bad;
        logic [15:0] s;
        logic [15:0] w;
        logic [15:0] p[$];
        logic [17:0] exp[$];
        rnd_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(2)) begin
                w = 16'($urandom);
                if (w[15:8] == 8'hA5) w[15:8] = 8'h5A;
                send(($urandom_range(1) == 0) ? 16'h00FF : w);
            end
            kind = $urandom_range(9);
            if (kind == 0) begin
                send(16'hA500);
                eer++;
            end else begin
                len = $urandom_range(1, 8);
                bad = (kind == 1);
                p.delete();
                s = 16'h0;
                for (int i = 0; i < len; i++) begin
                    p.push_back(16'($urandom));
                    s = s + p[i];
                end
                send({8'hA5, 8'(len)});
                foreach (p[i]) send(p[i]);
                send(bad ? (s ^ (16'h0001 << $urandom_range(15))) : s);
                for (int i = 0; i < len; i++)
                    exp.push_back({bad && (i == len - 1), i == len - 1, p[i]});
                if (bad) eer++;
                else eok++;
            end
        end
        rnd_ready = 1'b0;
        rdy_force = 1'b1;
        idle(40);
        checks++;
        if (got_q.size() - base != exp.size()) begin
            failures++;
            $display("FAIL rand_count got=%0d exp=%0d", got_q.size() - base, exp.size());
        end else begin
            foreach (exp[i]) begin
                checks++;
                if (got_q[base+i] !== exp[i]) begin
                    failures++;
                    $display("FAIL rand_beat%0d got=%h exp=%h", i, got_q[base+i], exp[i]);
                end
            end
        end
        checks++;
        if (ok_cnt - ok0 != eok || err_cnt - er0 != eer || ovf_o !== 1'b0) begin
            failures++;
            $display("FAIL rand_pulses got ok=%0d err=%0d ovf=%b exp ok=%0d err=%0d ovf=0",
                     ok_cnt - ok0, err_cnt - er0, ovf_o, eok, eer);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_sum();
        test_idle_len0();
        test_back_to_back();
        test_overflow();
        test_timeout();
        test_cfg_flush();
        test_rst_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
